// File: rtl/dmem_bus_pkg.sv
// Shared types and default widths for the data-memory bus bridge.
package dmem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STRB_W_DEF = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Cycle counter for the ADDR/RESP wait phases; expired fires on the cycle whose
// increment would bring the count to TIMEOUT. TIMEOUT = 0 disables it.
module dmem_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_bridge.sv
// Turns one held load/store request from the memory-access stage into a single
// valid/ready bus transaction, stalling the pipeline until the response returns.
module dmem_bus_bridge
    import dmem_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STRB_W  = STRB_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strobe,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_avalid,
    input  logic              bus_aready,
    output logic              bus_awrite,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rerr
);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:2]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q,  strb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q,   err_d;

    logic tmo_clear, tmo_en, tmo_expired;

    // The bus is word-addressed; byte offset is resolved upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_clear  = 1'b0;
        tmo_en     = 1'b0;
        req_ready  = 1'b0;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        bus_avalid = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stall     = 1'b1;
                    tmo_clear = 1'b1;
                    write_d   = req_write;
                    addr_d    = req_addr[ADDR_W-1:2];
                    wdata_d   = req_wdata;
                    strb_d    = req_write ? req_strobe : '0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    // A store that enables no bytes completes without touching the bus.
                    state_d   = (req_write && (req_strobe == '0)) ? DONE : ADDR;
                end
            end
            ADDR: begin
                stall      = 1'b1;
                bus_avalid = 1'b1;
                tmo_en     = 1'b1;
                if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus_aready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                stall  = 1'b1;
                tmo_en = 1'b1;
                if (bus_rvalid) begin
                    rdata_d = (write_q || bus_rerr) ? '0 : bus_rdata;
                    err_d   = bus_rerr;
                    state_d = DONE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: command and response registers are few and cheap, so all of them reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus and response outputs are zero outside their owning state.
    assign bus_awrite = bus_avalid & write_q;
    assign bus_addr   = bus_avalid ? {addr_q, 2'b00} : '0;
    assign bus_wdata  = bus_avalid ? wdata_q : '0;
    assign bus_wstrb  = bus_avalid ? strb_q : '0;
    assign rsp_rdata  = rsp_valid ? rdata_q : '0;
    assign rsp_err    = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: a reactive memory model drives the bus while
// expected responses are queued at request time and popped when rsp_valid fires.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strobe;
    logic        req_ready, stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_avalid, bus_aready, bus_awrite;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid, bus_rerr;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strobe (req_strobe),
        .req_ready  (req_ready),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus_avalid (bus_avalid),
        .bus_aready (bus_aready),
        .bus_awrite (bus_awrite),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_rerr   (bus_rerr)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one request; the memory accepts after a_dly address cycles and answers
    // r_dly cycles into RESP (negative = never). Called and returns at posedge+1.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int a_dly, input int r_dly,
                           input logic [31:0] mem_rdata, input logic mem_err,
                           input int exp_lat, input int exp_av,
                           input logic [31:0] exp_rdata, input logic exp_err);
        int   a_cnt = 0, r_cnt = 0, av_cnt = 0, rsp_cnt = 0;
        bit   acc = 1'b0, done_r = 1'b0;
        logic av_now, ar_now, rv_now;
        rsp_t e;
        exp_q.push_back('{exp_rdata, exp_err});
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_strobe = strb;
        for (int cyc = 0; cyc <= exp_lat + 1; cyc++) begin
            req_valid  = (cyc <= exp_lat);
            bus_aready = bus_avalid && (a_cnt == a_dly);
            bus_rvalid = acc && !done_r && (r_cnt == r_dly);
            bus_rdata  = bus_rvalid ? mem_rdata : 32'h5A5A_5A5A;
            bus_rerr   = bus_rvalid && mem_err;
            #1;
            check($sformatf("%s stall c%0d", tag, cyc), 32'(stall), 32'(cyc < exp_lat));
            check($sformatf("%s rsp_valid c%0d", tag, cyc), 32'(rsp_valid), 32'(cyc == exp_lat));
            check($sformatf("%s req_ready c%0d", tag, cyc), 32'(req_ready),
                  32'(cyc == 0 || cyc == exp_lat + 1));
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("%s rsp_rdata", tag), rsp_rdata, e.rdata);
                    check($sformatf("%s rsp_err", tag), 32'(rsp_err), 32'(e.err));
                end
            end
            if (bus_avalid) begin
                av_cnt++;
                check($sformatf("%s bus_addr c%0d", tag, cyc), bus_addr, {addr[31:2], 2'b00});
                check($sformatf("%s bus_awrite c%0d", tag, cyc), 32'(bus_awrite), 32'(wr));
                check($sformatf("%s bus_wstrb c%0d", tag, cyc), 32'(bus_wstrb), wr ? 32'(strb) : 32'd0);
                if (wr) check($sformatf("%s bus_wdata c%0d", tag, cyc), bus_wdata, wdata);
            end
            av_now = bus_avalid;
            ar_now = bus_aready;
            rv_now = bus_rvalid;
            @(posedge clk);
            #1;
            if (rv_now) done_r = 1'b1;
            else if (acc) r_cnt++;
            if (av_now && ar_now) acc = 1'b1;
            else if (av_now) a_cnt++;
        end
        bus_aready = 1'b0;
        bus_rvalid = 1'b0;
        bus_rerr   = 1'b0;
        check($sformatf("%s avalid cycles", tag), 32'(av_cnt), 32'(exp_av));
        check($sformatf("%s rsp count", tag), 32'(rsp_cnt), 32'd1);
        check($sformatf("%s scoreboard empty", tag), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_strobe = '0;
        bus_aready = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_rerr   = 1'b0;
        #12;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset bus_avalid", 32'(bus_avalid), 32'd0);
        check("reset bus_awrite", 32'(bus_awrite), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_wdata", bus_wdata, 32'd0);
        check("reset bus_wstrb", 32'(bus_wstrb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait load; strobes on a read must not reach the bus.
        run_txn("load0", 1'b0, 32'h0000_1003, 32'h0, 4'hF, 0, 0,
                32'hDEAD_BEEF, 1'b0, 3, 1, 32'hDEAD_BEEF, 1'b0);

        // Store with four cycles of address back-pressure.
        run_txn("store_bp", 1'b1, 32'h0000_2001, 32'h0000_AB00, 4'b0010, 4, 0,
                32'hCAFE_F00D, 1'b0, 7, 5, 32'h0, 1'b0);

        // Store with no byte enables completes without bus traffic.
        run_txn("store_nostrb", 1'b1, 32'h0000_3000, 32'h1234_5678, 4'b0000, 0, 0,
                32'h0, 1'b0, 1, 0, 32'h0, 1'b0);

        // Memory never accepts: timeout after 8 address cycles.
        run_txn("timeout", 1'b0, 32'h0000_4000, 32'h0, 4'h0, -1, -1,
                32'h0, 1'b0, 9, 8, 32'h0, 1'b1);

        // A late response in IDLE is ignored.
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1357_9BDF;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("late rvalid rsp_valid %0d", i), 32'(rsp_valid), 32'd0);
            check($sformatf("late rvalid stall %0d", i), 32'(stall), 32'd0);
            check($sformatf("late rvalid req_ready %0d", i), 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        bus_rvalid = 1'b0;

        // Bus error on a load, then a normal load.
        run_txn("load_rerr", 1'b0, 32'h0000_5008, 32'h0, 4'h0, 1, 2,
                32'h1122_3344, 1'b1, 6, 2, 32'h0, 1'b1);
        run_txn("load_after_err", 1'b0, 32'h0000_600C, 32'h0, 4'h0, 0, 1,
                32'h0BAD_F00D, 1'b0, 4, 1, 32'h0BAD_F00D, 1'b0);

        // Reset while waiting in RESP.
        req_write  = 1'b0;
        req_addr   = 32'h0000_2004;
        req_strobe = 4'h0;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus_aready = 1'b1;
        #1;
        check("rst_mid avalid in ADDR", 32'(bus_avalid), 32'd1);
        @(posedge clk);
        #1;
        bus_aready = 1'b0;
        #1;
        check("rst_mid stall in RESP", 32'(stall), 32'd1);
        check("rst_mid avalid in RESP", 32'(bus_avalid), 32'd0);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_mid req_ready", 32'(req_ready), 32'd1);
        check("rst_mid stall", 32'(stall), 32'd0);
        check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid bus_avalid", 32'(bus_avalid), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        check("rst_mid held rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid released req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rst_mid stale rvalid ignored", 32'(rsp_valid), 32'd0);
        check("rst_mid stale rvalid stall", 32'(stall), 32'd0);
        bus_rvalid = 1'b0;

        run_txn("load_after_rst", 1'b0, 32'h0000_7000, 32'h0, 4'h0, 2, 0,
                32'h7654_3210, 1'b0, 5, 3, 32'h7654_3210, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
